// File: rtl/cpu6502_bus_pkg.sv
// Shared types for the external data-bus writer: FSM states, queue entry,
// registered bus output bundle and the idle data value.
package cpu6502_bus_pkg;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

`ifdef DATA_BUS_WRITER_HOLD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } bus_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2
  } bus_state_t;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        oe;
  } bus_out_t;

  function automatic bus_out_t idle_out(
    input logic [7:0] d
  );
    return '{addr: 16'h0000, data: d,
             rw: 1'b1, oe: 1'b0};
  endfunction

  function automatic bus_out_t setup_out(
    input wr_entry_t e
  );
    return '{addr: e.addr, data: e.data,
             rw: 1'b0, oe: 1'b0};
  endfunction

endpackage

// File: rtl/write_queue.sv
// Posted-write FIFO, DEPTH entries of W bits, sync active-high reset.
// Ports: clk, reset, push/din, pop, dout (head), dout_next (entry behind
// head), full, empty, more (two or more entries held).
module write_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] dout_next,
  output logic         full,
  output logic         empty,
  output logic         more
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0
                                 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign more      = (count > CW'(1));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign dout      = mem[rd_ptr];
  assign dout_next = mem[inc(rd_ptr)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

endmodule

// File: rtl/data_bus_writer.sv
// Posted-write engine: queues internal-bus writes and replays them on the
// external bus as SETUP/DRIVE cycles with i_ready wait states.
// Ports: i_clk, i_reset (sync, active-high), i_clk_en (phase enable),
// i_load/i_address/i_data (post write), i_ready (memory accept),
// o_address/o_data/o_rw/o_oe (external bus), o_full, o_busy, o_overflow.
// Define DATA_BUS_WRITER_HOLD_EN to add a one-cycle HOLD after each write.
// DEPTH must be 2 or 4.
module data_bus_writer
  import cpu6502_bus_pkg::*;
#(
  parameter int         DEPTH     = 2,
  parameter logic [7:0] IDLE_DATA = BUS_IDLE_DATA
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_load,
  input  logic [7:0]  i_data,
  input  logic [15:0] i_address,
  input  logic        i_ready,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_rw,
  output logic        o_oe,
  output logic        o_full,
  output logic        o_busy,
  output logic        o_overflow
);

  bus_state_t state;
  bus_out_t   out_q;
  wr_entry_t  q_in;
  wr_entry_t  q_head;
  wr_entry_t  q_second;
  logic       q_full;
  logic       q_empty;
  logic       q_more;
  logic       push;
  logic       pop;
  logic       overflow;

  assign q_in = '{addr: i_address, data: i_data};
  assign push = i_clk_en & i_load & ~q_full;
  assign pop  = i_clk_en & i_ready
              & (state == ST_DRIVE);

  write_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(wr_entry_t))
  ) u_queue (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .pop       (pop),
    .din       (q_in),
    .dout      (q_head),
    .dout_next (q_second),
    .full      (q_full),
    .empty     (q_empty),
    .more      (q_more)
  );

`ifndef DATA_BUS_WRITER_HOLD_EN
  // After a pop the next head is the entry behind it, or the entry being
  // pushed on this same edge when the popped one was the last.
  wr_entry_t next_head;
  logic      has_next;
  assign next_head = q_more ? q_second : q_in;
  assign has_next  = q_more | push;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      out_q    <= idle_out(IDLE_DATA);
      overflow <= 1'b0;
    end else if (i_clk_en) begin
      if (i_load && q_full) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            state <= ST_SETUP;
            out_q <= setup_out(q_head);
          end
        end
        ST_SETUP: begin
          state    <= ST_DRIVE;
          out_q.oe <= 1'b1;
        end
        ST_DRIVE: begin
          if (i_ready) begin
`ifdef DATA_BUS_WRITER_HOLD_EN
            state    <= ST_HOLD;
            out_q.rw <= 1'b1;
`else
            if (has_next) begin
              state <= ST_SETUP;
              out_q <= setup_out(next_head);
            end else begin
              state <= ST_IDLE;
              out_q <= idle_out(IDLE_DATA);
            end
`endif
          end
        end
`ifdef DATA_BUS_WRITER_HOLD_EN
        ST_HOLD: begin
          if (!q_empty) begin
            state <= ST_SETUP;
            out_q <= setup_out(q_head);
          end else begin
            state <= ST_IDLE;
            out_q <= idle_out(IDLE_DATA);
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          out_q <= idle_out(IDLE_DATA);
        end
      endcase
    end
  end

  assign o_address  = out_q.addr;
  assign o_data     = out_q.data;
  assign o_rw       = out_q.rw;
  assign o_oe       = out_q.oe;
  assign o_full     = q_full;
  assign o_busy     = (state != ST_IDLE) | ~q_empty;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_data_bus_writer.sv
// Directed bench for data_bus_writer (DEPTH=2); follows the HOLD build
// when DATA_BUS_WRITER_HOLD_EN is defined.
module tb_data_bus_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        load;
  logic [7:0]  din;
  logic [15:0] ain;
  logic        ready;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic        o_rw;
  logic        o_oe;
  logic        o_full;
  logic        o_busy;
  logic        o_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_bus_writer #(.DEPTH(2)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_clk_en   (clk_en),
    .i_load     (load),
    .i_data     (din),
    .i_address  (ain),
    .i_ready    (ready),
    .o_address  (o_address),
    .o_data     (o_data),
    .o_rw       (o_rw),
    .o_oe       (o_oe),
    .o_full     (o_full),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rw"},   32'(o_rw),      32'h1);
    chk({tag, "_oe"},   32'(o_oe),      32'h0);
    chk({tag, "_data"}, 32'(o_data),    32'hFF);
    chk({tag, "_addr"}, 32'(o_address), 32'h0);
  endtask

  task automatic chk_bus(input string tag,
                         input logic [15:0] a,
                         input logic [7:0] d,
                         input logic rw,
                         input logic oe);
    chk({tag, "_addr"}, 32'(o_address), 32'(a));
    chk({tag, "_data"}, 32'(o_data),    32'(d));
    chk({tag, "_rw"},   32'(o_rw),      32'(rw));
    chk({tag, "_oe"},   32'(o_oe),      32'(oe));
  endtask

  // Called right after the pop edge: in the HOLD build one extra cycle
  // shows rw=1/oe=1 with data and address kept.
  task automatic after_pop(input string tag,
                           input logic [15:0] a,
                           input logic [7:0] d);
`ifdef DATA_BUS_WRITER_HOLD_EN
    chk_bus({tag, "_hold"}, a, d, 1'b1, 1'b1);
    step();
`else
    chk({tag, "_noholdaddr"}, 32'(o_address), 32'h0);
    if (a == 16'hFFFF) chk("unreach", 32'(d), 32'(d));
`endif
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    load   = 1'b0;
    din    = 8'h00;
    ain    = 16'h0000;
    ready  = 1'b0;
    step();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_busy", 32'(o_busy),     32'h0);
    chk("reset_full", 32'(o_full),     32'h0);
    chk("reset_ovf",  32'(o_overflow), 32'h0);

    // single write, memory ready
    ready = 1'b1;
    load  = 1'b1;
    ain   = 16'h0200;
    din   = 8'h5A;
    step();
    load = 1'b0;
    chk("w1_busy_q", 32'(o_busy), 32'h1);
    chk("w1_rw_q",   32'(o_rw),   32'h1);
    step();
    chk("w1_setup_rw",   32'(o_rw),      32'h0);
    chk("w1_setup_oe",   32'(o_oe),      32'h0);
    chk("w1_setup_addr", 32'(o_address), 32'h0200);
    step();
    chk_bus("w1_drive", 16'h0200, 8'h5A, 1'b0, 1'b1);
    step();
    after_pop("w1", 16'h0200, 8'h5A);
    chk_idle("w1_end");
    chk("w1_end_busy", 32'(o_busy), 32'h0);

    // wait states: ready low for three DRIVE cycles
    ready = 1'b0;
    load  = 1'b1;
    ain   = 16'h1234;
    din   = 8'hC3;
    step();
    load = 1'b0;
    step();
    chk_bus("ws_setup", 16'h1234, 8'hC3, 1'b0, 1'b0);
    step();
    chk_bus("ws_drive0", 16'h1234, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bus("ws_wait", 16'h1234, 8'hC3, 1'b0, 1'b1);
    end
    ready = 1'b1;
    step();
    after_pop("ws", 16'h1234, 8'hC3);
    chk_idle("ws_end");
    chk("ws_end_busy", 32'(o_busy), 32'h0);

    // overflow: three pushes into a two-deep queue
    ready = 1'b0;
    load  = 1'b1;
    ain   = 16'h0300;
    din   = 8'h11;
    step();
    ain = 16'h0301;
    din = 8'h22;
    step();
    chk("ov_full", 32'(o_full), 32'h1);
    chk("ov_pre",  32'(o_overflow), 32'h0);
    ain = 16'h0302;
    din = 8'h33;
    step();
    load = 1'b0;
    chk("ov_flag", 32'(o_overflow), 32'h1);
    chk("ov_full2", 32'(o_full), 32'h1);
    chk_bus("ov_drv1", 16'h0300, 8'h11, 1'b0, 1'b1);
    ready = 1'b1;
    step();
`ifdef DATA_BUS_WRITER_HOLD_EN
    chk_bus("ov_hold1", 16'h0300, 8'h11, 1'b1, 1'b1);
    step();
`endif
    chk_bus("ov_set2", 16'h0301, 8'h22, 1'b0, 1'b0);
    chk("ov_notfull", 32'(o_full), 32'h0);
    step();
    chk_bus("ov_drv2", 16'h0301, 8'h22, 1'b0, 1'b1);
    step();
    after_pop("ov", 16'h0301, 8'h22);
    chk_idle("ov_end");
    chk("ov_end_busy", 32'(o_busy), 32'h0);
    chk("ov_sticky",   32'(o_overflow), 32'h1);

    // clock enable low for five edges while in SETUP
    ready = 1'b0;
    load  = 1'b1;
    ain   = 16'h0400;
    din   = 8'h44;
    step();
    load = 1'b0;
    step();
    chk_bus("ce_setup", 16'h0400, 8'h44, 1'b0, 1'b0);
    clk_en = 1'b0;
    load   = 1'b1;
    ready  = 1'b1;
    ain    = 16'h0500;
    din    = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("ce_frozen", 16'h0400, 8'h44, 1'b0, 1'b0);
    end
    clk_en = 1'b1;
    load   = 1'b0;
    ready  = 1'b0;
    step();
    chk_bus("ce_drive", 16'h0400, 8'h44, 1'b0, 1'b1);
    ready = 1'b1;
    step();
    after_pop("ce", 16'h0400, 8'h44);
    chk_idle("ce_end");
    chk("ce_nopush", 32'(o_busy), 32'h0);

    // reset in the middle of DRIVE with another entry pending
    ready = 1'b0;
    load  = 1'b1;
    ain   = 16'h0600;
    din   = 8'h66;
    step();
    ain = 16'h0601;
    din = 8'h67;
    step();
    load = 1'b0;
    step();
    chk_bus("rd_drive", 16'h0600, 8'h66, 1'b0, 1'b1);
    rst    = 1'b1;
    clk_en = 1'b0;
    step();
    chk_idle("rd_rst");
    chk("rd_busy", 32'(o_busy),     32'h0);
    chk("rd_ovf",  32'(o_overflow), 32'h0);
    chk("rd_full", 32'(o_full),     32'h0);
    rst    = 1'b0;
    clk_en = 1'b1;
    step();
    step();
    chk_idle("rd_after");
    chk("rd_after_busy", 32'(o_busy), 32'h0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
